// File: rtl/db_pkg.sv
// Shared encodings for the n-way filter table controller: filter states,
// request op fields, controller FSM states and response flag bit positions.
package db_pkg;

   typedef enum logic [1:0] {
      FltIdle    = 2'b00,
      FltSuspect = 2'b01,
      FltArrest  = 2'b10,
      FltExpire  = 2'b11
   } flt_state_e;

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StRd,
      StCmp,
      StWr
   } fsm_state_e;

   localparam int unsigned OpSetBit     = 0;
   localparam int unsigned OpStLsb      = 1;

   localparam int unsigned FlagHitBit   = 0;
   localparam int unsigned FlagStLsb    = 1;
   localparam int unsigned FlagStaleBit = 3;

endpackage

// File: rtl/kv_way_ram.sv
// One way of the set-associative table: single-port RAM, one-cycle registered
// read, read-before-write on a shared address.
module kv_way_ram #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk156,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk156) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/db_cont_nway.sv
// WAYS-way hash table controller: per-flow filter state with ageing, replacement,
// a clear sweep after reset and a ready/valid request interface.
module db_cont_nway
   import db_pkg::*;
#(
   parameter int unsigned HASH_SIZE = 32,
   parameter int unsigned KEY_SIZE  = 96,
   parameter int unsigned VAL_SIZE  = 32,
   parameter int unsigned RAM_ADDR  = 10,
   parameter int unsigned WAYS      = 2,
   parameter int unsigned TS_WIDTH  = 16,
   parameter int unsigned TICK_DIV  = 24,
   parameter int unsigned TIMEOUT   = 100
) (
   input  logic                 clk156,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_op,
   input  logic [HASH_SIZE-1:0] in_hash,
   input  logic [KEY_SIZE-1:0]  in_key,
   input  logic [VAL_SIZE-1:0]  in_value,
   output logic                 out_valid,
   output logic [3:0]           out_flag,
   output logic [VAL_SIZE-1:0]  out_value
);

   // Entry layout, MSB first: {valid, state, ts, value, key}
   localparam int unsigned ValLo  = KEY_SIZE;
   localparam int unsigned TsLo   = KEY_SIZE + VAL_SIZE;
   localparam int unsigned StLo   = TsLo + TS_WIDTH;
   localparam int unsigned VldBit = StLo + 2;
   localparam int unsigned EntW   = VldBit + 1;
   localparam int unsigned WayW   = (WAYS > 1) ? $clog2(WAYS) : 1;

   fsm_state_e            state_q, state_d;
   logic [RAM_ADDR:0]     init_cnt_q, init_cnt_d;
   logic [TICK_DIV-1:0]   presc_q;
   logic [TS_WIDTH-1:0]   sys_ts_q;
   logic [WayW-1:0]       rr_q, rr_d;

   logic                  req_set_q;
   flt_state_e            req_st_q;
   logic [RAM_ADDR-1:0]   req_idx_q;
   logic [KEY_SIZE-1:0]   req_key_q;
   logic [VAL_SIZE-1:0]   req_val_q;

   logic [WayW-1:0]       wr_way_q, wr_way_d;
   logic [EntW-1:0]       wr_ent_q, wr_ent_d;
   logic                  do_wr;

   logic                  out_valid_q;
   logic [3:0]            out_flag_q, resp_flag;
   logic [VAL_SIZE-1:0]   out_value_q, resp_value;

   logic [EntW-1:0]       rd_ent [WAYS];
   logic [WAYS-1:0]       ram_we, way_match, way_live;
   logic [RAM_ADDR-1:0]   ram_addr;
   logic [EntW-1:0]       ram_wdata;

   logic                  match_any, any_free, hit, stale;
   logic [WayW-1:0]       match_way, free_way;
   logic [EntW-1:0]       cur_ent;
   flt_state_e            cur_st, new_st;
   logic [VAL_SIZE-1:0]   cur_val;

   logic                  unused_in;
   assign unused_in = ^{in_hash[HASH_SIZE-1:RAM_ADDR], in_op[3]};

   assign ram_addr  = (state_q == StInit) ? init_cnt_q[RAM_ADDR-1:0] : req_idx_q;
   assign ram_wdata = (state_q == StInit) ? '0 : wr_ent_q;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [TS_WIDTH-1:0] age;

      kv_way_ram #(
         .ADDR_W (RAM_ADDR),
         .DATA_W (EntW)
      ) u_ram (
         .clk156 (clk156),
         .we     (ram_we[w]),
         .addr   (ram_addr),
         .wdata  (ram_wdata),
         .rdata  (rd_ent[w])
      );

      assign ram_we[w] = ((state_q == StInit) && !init_cnt_q[RAM_ADDR]) ||
                         ((state_q == StWr) && (wr_way_q == WayW'(w)));
      // Modular subtraction keeps ages correct across sys_ts wrap.
      assign age          = sys_ts_q - rd_ent[w][TsLo +: TS_WIDTH];
      assign way_live[w]  = rd_ent[w][VldBit] && (age < TS_WIDTH'(TIMEOUT));
      assign way_match[w] = rd_ent[w][VldBit] && (rd_ent[w][KEY_SIZE-1:0] == req_key_q);
   end

   always_comb begin
      match_any = 1'b0;
      match_way = '0;
      any_free  = 1'b0;
      free_way  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (way_match[w] && !match_any) begin
            match_any = 1'b1;
            match_way = WayW'(w);
         end
         if (!way_live[w] && !any_free) begin
            any_free = 1'b1;
            free_way = WayW'(w);
         end
      end
   end

   assign cur_ent = rd_ent[match_way];
   assign cur_st  = flt_state_e'(cur_ent[StLo +: 2]);
   assign cur_val = cur_ent[ValLo +: VAL_SIZE];
   assign hit     = match_any && way_live[match_way];
   assign stale   = match_any && !way_live[match_way];

   always_comb begin
      resp_flag  = '0;
      resp_value = '0;
      do_wr      = 1'b0;
      wr_way_d   = '0;
      wr_ent_d   = '0;
      rr_d       = rr_q;
      new_st     = FltIdle;
      resp_flag[FlagStaleBit] = stale;
      if (hit) begin
         resp_flag[FlagHitBit]     = 1'b1;
         resp_flag[FlagStLsb +: 2] = cur_st;
         resp_value                = cur_val;
         if (req_set_q) begin
            case (req_st_q)
               FltSuspect, FltArrest: begin
                  // SUSPECT never downgrades an ARREST entry
                  new_st = ((req_st_q == FltSuspect) && (cur_st == FltArrest)) ?
                           FltArrest : req_st_q;
                  do_wr    = 1'b1;
                  wr_way_d = match_way;
                  wr_ent_d = {1'b1, new_st, sys_ts_q, req_val_q, req_key_q};
                  resp_flag[FlagStLsb +: 2] = new_st;
                  resp_value = req_val_q;
               end
               FltExpire: begin
                  do_wr            = 1'b1;
                  wr_way_d         = match_way;
                  wr_ent_d         = cur_ent;
                  wr_ent_d[VldBit] = 1'b0;
                  resp_flag        = '0;
                  resp_flag[FlagStLsb +: 2] = FltExpire;
                  resp_value       = '0;
               end
               default: ;
            endcase
         end
      end else if (req_set_q && ((req_st_q == FltSuspect) || (req_st_q == FltArrest))) begin
         do_wr    = 1'b1;
         wr_ent_d = {1'b1, req_st_q, sys_ts_q, req_val_q, req_key_q};
         if (stale) begin
            wr_way_d = match_way;
         end else if (any_free) begin
            wr_way_d = free_way;
         end else begin
            wr_way_d = rr_q;
            rr_d     = (rr_q == WayW'(WAYS - 1)) ? '0 : rr_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      unique case (state_q)
         StInit: begin
            if (init_cnt_q[RAM_ADDR]) begin
               state_d = StIdle;
            end else begin
               init_cnt_d = init_cnt_q + 1'b1;
            end
         end
         StIdle:  if (in_valid) state_d = StRd;
         StRd:    state_d = StCmp;
         StCmp:   state_d = do_wr ? StWr : StIdle;
         StWr:    state_d = StIdle;
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk156) begin
      if (rst) begin
         state_q     <= StInit;
         init_cnt_q  <= '0;
         presc_q     <= '0;
         sys_ts_q    <= '0;
         rr_q        <= '0;
         out_valid_q <= 1'b0;
         out_flag_q  <= '0;
         out_value_q <= '0;
         wr_way_q    <= '0;
         wr_ent_q    <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         presc_q     <= presc_q + 1'b1;
         if (&presc_q) begin
            sys_ts_q <= sys_ts_q + 1'b1;
         end
         out_valid_q <= (state_q == StCmp);
         if (state_q == StCmp) begin
            out_flag_q  <= resp_flag;
            out_value_q <= resp_value;
            wr_way_q    <= wr_way_d;
            wr_ent_q    <= wr_ent_d;
            rr_q        <= rr_d;
         end
      end
   end

   always_ff @(posedge clk156) begin
      if ((state_q == StIdle) && in_valid) begin
         req_set_q <= in_op[OpSetBit];
         req_st_q  <= flt_state_e'(in_op[OpStLsb +: 2]);
         req_idx_q <= in_hash[RAM_ADDR-1:0];
         req_key_q <= in_key;
         req_val_q <= in_value;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign out_flag  = out_flag_q;
   assign out_value = out_value_q;

endmodule
